// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered full/empty/threshold flags, occupancy count
// and sticky overflow/underflow; FWFT selects registered-read or fall-through output.
module sync_fifo_flags #(
  parameter int unsigned DATASIZE      = 12,
  parameter int unsigned ADDRSIZE      = 8,
  parameter int unsigned AFULL_THRESH  = (32'd1 << ADDRSIZE) - 32'd4,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter int unsigned FWFT          = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_enable,
  input  logic [DATASIZE-1:0] write_data,
  input  logic                read_enable,
  input  logic                clear_errors,
  output logic [DATASIZE-1:0] read_data,
  output logic                write_full,
  output logic                read_empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned DEPTH = 32'd1 << ADDRSIZE;
  localparam int unsigned CW    = ADDRSIZE + 1;

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE-1:0] wr_ptr, rd_ptr;
  logic [ADDRSIZE-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]       count_nxt, count_after_rd;
  logic [DATASIZE-1:0] read_data_nxt;
  logic                wr_acc, rd_acc;
  logic                write_full_nxt, read_empty_nxt;
  logic                almost_full_nxt, almost_empty_nxt;
  logic                overflow_nxt, underflow_nxt;

  // Acceptance uses the registered flags, so a write while full is dropped even
  // when a read frees a slot in the same cycle.
  always_comb begin
    wr_acc         = write_enable & ~write_full;
    rd_acc         = read_enable & ~read_empty;
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    if (wr_acc) wr_ptr_nxt = wr_ptr + ADDRSIZE'(1);
    if (rd_acc) rd_ptr_nxt = rd_ptr + ADDRSIZE'(1);
    count_after_rd = rd_acc ? count - CW'(1) : count;
    count_nxt      = wr_acc ? count_after_rd + CW'(1) : count_after_rd;
  end

  // Status flags are registered from the next-state count.
  always_comb begin
    write_full_nxt   = (count_nxt == CW'(DEPTH));
    read_empty_nxt   = (count_nxt == '0);
    almost_full_nxt  = (count_nxt >= CW'(AFULL_THRESH));
    almost_empty_nxt = (count_nxt <= CW'(AEMPTY_THRESH));
  end

  // Sticky errors: a fresh set condition overrides a simultaneous clear.
  always_comb begin
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    if (clear_errors) begin
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end
    if (write_enable && write_full) overflow_nxt  = 1'b1;
    if (read_enable && read_empty)  underflow_nxt = 1'b1;
  end

  // Fall-through mode presents the next head every cycle; when the head is the
  // word being written right now, it is bypassed straight from write_data.
  always_comb begin
    read_data_nxt = read_data;
    if (FWFT != 0) begin
      if (count_after_rd != '0) begin
        read_data_nxt = mem[rd_ptr_nxt];
      end else if (wr_acc) begin
        read_data_nxt = write_data;
      end
    end else if (rd_acc) begin
      read_data_nxt = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      read_data    <= '0;
      write_full   <= 1'b0;
      read_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      read_data    <= read_data_nxt;
      write_full   <= write_full_nxt;
      read_empty   <= read_empty_nxt;
      almost_full  <= almost_full_nxt;
      almost_empty <= almost_empty_nxt;
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

  // Storage is not reset; writes during reset are suppressed.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr] <= write_data;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed and reference-queue checks for sync_fifo_flags in both read modes.
module tb_sync_fifo_flags;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [11:0] wd = '0;
  logic [11:0] rd;
  logic        full, empty, afull, aempty, ovf, unf;
  logic [8:0]  cnt;

  logic        fw_we = 1'b0, fw_re = 1'b0;
  logic [11:0] fw_wd = '0;
  logic [11:0] fw_rd;
  logic        fw_full, fw_empty, fw_afull, fw_aempty, fw_ovf, fw_unf;
  logic [8:0]  fw_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flags dut (
    .clk(clk), .reset(reset), .write_enable(we), .write_data(wd),
    .read_enable(re), .clear_errors(clr), .read_data(rd),
    .write_full(full), .read_empty(empty), .almost_full(afull),
    .almost_empty(aempty), .count(cnt), .overflow(ovf), .underflow(unf)
  );

  sync_fifo_flags #(.FWFT(1)) dut_fw (
    .clk(clk), .reset(reset), .write_enable(fw_we), .write_data(fw_wd),
    .read_enable(fw_re), .clear_errors(1'b0), .read_data(fw_rd),
    .write_full(fw_full), .read_empty(fw_empty), .almost_full(fw_afull),
    .almost_empty(fw_aempty), .count(fw_cnt), .overflow(fw_ovf), .underflow(fw_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus to the registered-read instance, then idle.
  task automatic step(input logic w, input logic [11:0] d, input logic r, input logic c);
    we = w; wd = d; re = r; clr = c;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic fw_step(input logic w, input logic [11:0] d, input logic r);
    fw_we = w; fw_wd = d; fw_re = r;
    @(posedge clk); #1;
    fw_we = 1'b0; fw_re = 1'b0;
  endtask

  logic [11:0] q[$];
  logic [11:0] exp_d;
  int          max_cnt;
  logic        w, r, wacc, racc;

  initial begin
    // Reset state
    reset = 1'b1;
    step(1'b0, 12'h0, 1'b0, 1'b0);
    reset = 1'b0;
    check("rst_count", 32'(cnt), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(aempty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_afull", 32'(afull), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_unf", 32'(unf), 32'd0);
    check("rst_rdata", 32'(rd), 32'd0);
    check("fw_rst_empty", 32'(fw_empty), 32'd1);

    // Fall-through: first word visible without a read, bypass on read+write at count 1
    fw_step(1'b1, 12'h5A5, 1'b0);
    check("fw_first_empty", 32'(fw_empty), 32'd0);
    check("fw_first_data", 32'(fw_rd), 32'h5A5);
    fw_step(1'b1, 12'h111, 1'b0);
    check("fw_head_hold", 32'(fw_rd), 32'h5A5);
    check("fw_count2", 32'(fw_cnt), 32'd2);
    fw_step(1'b0, 12'h0, 1'b1);
    check("fw_pop_next", 32'(fw_rd), 32'h111);
    fw_step(1'b1, 12'h333, 1'b1);
    check("fw_bypass_data", 32'(fw_rd), 32'h333);
    check("fw_bypass_count", 32'(fw_cnt), 32'd1);
    fw_step(1'b0, 12'h0, 1'b1);
    check("fw_drain_empty", 32'(fw_empty), 32'd1);
    check("fw_drain_count", 32'(fw_cnt), 32'd0);

    // Fill 256 words with threshold tracking
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b0);
      check("fill_count", 32'(cnt), 32'(i));
      check("fill_afull", 32'(afull), 32'(i >= 252));
      check("fill_aempty", 32'(aempty), 32'(i <= 4));
      check("fill_full", 32'(full), 32'(i == 256));
    end

    // Write while full with a simultaneous read: read proceeds, write dropped
    step(1'b1, 12'hFFF, 1'b1, 1'b0);
    check("ovf_count", 32'(cnt), 32'd255);
    check("ovf_full", 32'(full), 32'd0);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_rdata", 32'(rd), 32'h001);

    for (int i = 2; i <= 256; i++) begin
      step(1'b0, 12'h0, 1'b1, 1'b0);
      check("drain_data", 32'(rd), 32'(i));
      check("drain_count", 32'(cnt), 32'(256 - i));
      check("drain_aempty", 32'(aempty), 32'((256 - i) <= 4));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Read while empty: rejected, data held, underflow set
    step(1'b0, 12'h0, 1'b1, 1'b0);
    check("unf_flag", 32'(unf), 32'd1);
    check("unf_rdata_hold", 32'(rd), 32'h100);
    check("unf_count", 32'(cnt), 32'd0);

    // Clear vs set in the same cycle, then plain clear
    step(1'b0, 12'h0, 1'b1, 1'b1);
    check("clr_set_wins", 32'(unf), 32'd1);
    check("clr_ovf", 32'(ovf), 32'd0);
    step(1'b0, 12'h0, 1'b0, 1'b1);
    check("clr_unf", 32'(unf), 32'd0);

    // Read+write on empty: write proceeds, read rejected
    step(1'b1, 12'hABC, 1'b1, 1'b0);
    check("rw_empty_unf", 32'(unf), 32'd1);
    check("rw_empty_count", 32'(cnt), 32'd1);
    check("rw_empty_rdata", 32'(rd), 32'h100);
    step(1'b0, 12'h0, 1'b1, 1'b0);
    check("rw_empty_pop", 32'(rd), 32'hABC);
    check("rw_empty_count0", 32'(cnt), 32'd0);

    // Mixed traffic against a reference queue: write-heavy, then read-heavy
    max_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (i < 300) begin
        w = ($urandom_range(99) < 85);
        r = ($urandom_range(99) < 30);
      end else begin
        w = ($urandom_range(99) < 30);
        r = ($urandom_range(99) < 85);
      end
      exp_d = 12'($urandom);
      wacc = w && (q.size() < 256);
      racc = r && (q.size() > 0);
      step(w, exp_d, r, 1'b0);
      if (racc) check("mix_data", 32'(rd), 32'(q.pop_front()));
      if (wacc) q.push_back(exp_d);
      check("mix_count", 32'(cnt), 32'(q.size()));
      if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
    end
    check("mix_max_count", 32'(max_cnt <= 256), 32'd1);

    // Reset with count=100 and overflow set
    reset = 1'b1;
    step(1'b0, 12'h0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) step(1'b1, 12'(i + 7), 1'b0, 1'b0);
    step(1'b1, 12'h0, 1'b0, 1'b0);
    for (int i = 0; i < 156; i++) step(1'b0, 12'h0, 1'b1, 1'b0);
    check("pre_rst_count", 32'(cnt), 32'd100);
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    check("pre_rst_rdata", 32'(rd), 32'(155 + 7));
    reset = 1'b1;
    step(1'b1, 12'h777, 1'b1, 1'b0);
    reset = 1'b0;
    check("midrst_count", 32'(cnt), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_ovf", 32'(ovf), 32'd0);
    check("midrst_rdata", 32'(rd), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    step(1'b1, 12'h123, 1'b0, 1'b0);
    step(1'b0, 12'h0, 1'b1, 1'b0);
    check("post_rst_data", 32'(rd), 32'h123);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DATASIZE, default 12, data word width.
REQ-002 SHALL have parameter ADDRSIZE, default 8, address bits; DEPTH = 1<<ADDRSIZE entries, all usable.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-4, almost_full level; legal range AEMPTY_THRESH < AFULL_THRESH <= DEPTH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4, almost_empty level; legal range 0 <= AEMPTY_THRESH < AFULL_THRESH.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port write_enable, input, 1, push request.
REQ-009 SHALL have port write_data, input, DATASIZE, push data.
REQ-010 SHALL have port read_enable, input, 1, pop request.
REQ-011 SHALL have port clear_errors, input, 1, clears sticky error flags.
REQ-012 SHALL have port read_data, output, DATASIZE, pop data.
REQ-013 SHALL have ports write_full and read_empty, output, 1 each, full and empty status.
REQ-014 SHALL have ports almost_full and almost_empty, output, 1 each, threshold status.
REQ-015 SHALL have port count, output, ADDRSIZE+1, current occupancy 0..DEPTH.
REQ-016 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-017 SHALL accept a write when write_enable=1 and write_full=0; the word is stored at the write pointer and the pointer advances modulo DEPTH.
REQ-018 SHALL accept a read when read_enable=1 and read_empty=0; the read pointer advances modulo DEPTH.
REQ-019 SHALL, on a write while full, keep memory, pointers and count unchanged, even if a read is accepted in the same cycle (read proceeds, write dropped).
REQ-020 SHALL, on a read while empty, reject the read (pointers, count and read_data unchanged), even if a write is accepted in the same cycle (write proceeds).
REQ-021 SHALL update count each cycle as +1 (write only accepted), -1 (read only accepted), or unchanged (both or neither accepted).
REQ-022 SHALL register all status outputs from next-state count: write_full = (count==DEPTH), read_empty = (count==0), almost_full = (count>=AFULL_THRESH), almost_empty = (count<=AEMPTY_THRESH).
REQ-023 SHALL, with FWFT=0, load read_data with the head word on the edge that accepts a read (data valid the cycle after the read_enable cycle) and hold it otherwise.
REQ-024 SHALL, with FWFT=1, drive read_data with the head word whenever read_empty=0; the first write into an empty FIFO appears on read_data the cycle read_empty falls; the accepting read exposes the next word the following cycle.
REQ-025 SHALL set overflow on any cycle with write_enable=1 and write_full=1, and underflow on any cycle with read_enable=1 and read_empty=1; both flags hold until cleared.
REQ-026 SHALL clear overflow and underflow on clear_errors=1; a new set condition in the same cycle wins.
REQ-027 SHALL keep pointer wrap transparent: data order preserved across any number of wraps.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set both pointers to 0, count=0, read_empty=1, almost_empty=1, write_full=0, almost_full=0, overflow=0, underflow=0, read_data=0; memory contents are not reset.
REQ-029 SHALL give reset priority over all other inputs, including mid-operation and when full; writes and reads in the reset cycle are ignored.

Verification
REQ-030 SHALL pass: defaults, FWFT=0, write 0x001..0x100 (256 words) -> write_full=1 after 256th edge, almost_full from count 252, count=256; then read 256 -> data 0x001..0x100 in order, read_empty=1, almost_empty from count 4.
REQ-031 SHALL pass: full FIFO, read_enable=1 and write_enable=1 same cycle -> count 255, write_full=0, overflow=1, dropped word never read.
REQ-032 SHALL pass: empty FIFO, read_enable=1 and write_enable=1 with 0xABC -> underflow=1, count=1, next read returns 0xABC.
REQ-033 SHALL pass: FWFT=1, write 0x5A5 into empty FIFO -> next cycle read_empty=0 and read_data=0x5A5 with no read issued.
REQ-034 SHALL pass: 600 mixed push/pop transactions spanning multiple pointer wraps -> output sequence matches reference queue, count never exceeds 256.
REQ-035 SHALL pass: reset asserted with count=100 and overflow=1 -> next cycle count=0, read_empty=1, overflow=0, read_data=0.
